vx_tex_arbiter: RTL and testbench

Shares one texture unit request/response channel among NUM_REQS requesters such as per-core or per-socket texture clients. Round-robin arbitration selects one request per cycle. The requester index is appended to the tag, and each response is routed back to its requester by that index. Per-requester pending counters bound the number of outstanding requests so that one requester cannot monopolise the unit.

---
 rtl/vx_tex_arbiter_pkg.sv | 25 ++
 rtl/vx_tex_arbiter_if.sv | 32 +++
 rtl/vx_tex_arb_credit.sv | 43 ++++
 rtl/vx_tex_arbiter.sv | 170 +++++++++++++++++
 tb/tb_vx_tex_arbiter.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vx_tex_arbiter_pkg.sv
// Shared widths and the request payload type for the texture-unit arbiter.
// Optional perf counters are enabled by defining TEX_ARB_PERF_EN.
package vx_tex_arbiter_pkg;

    localparam int NUM_REQS      = 4;
    localparam int NUM_LANES     = 4;
    localparam int TAG_WIDTH     = 8;
    localparam int MAX_PENDING   = 8;
    localparam int LOD_BITS      = 4;
    localparam int STAGE_BITS    = 2;
    localparam int PERF_CTR_BITS = 16;

    localparam int IDX_W     = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
    localparam int OUT_TAG_W = TAG_WIDTH + IDX_W;
    localparam int CNT_W     = $clog2(MAX_PENDING + 1);

    typedef struct packed {
        logic [NUM_LANES-1:0]                mask;
        logic [1:0][NUM_LANES-1:0][31:0]     coords;
        logic [NUM_LANES-1:0][LOD_BITS-1:0]  lod;
        logic [STAGE_BITS-1:0]               stage;
        logic [OUT_TAG_W-1:0]                tag;
    } tex_req_t;

endpackage

// File: rtl/vx_tex_arbiter_if.sv
// Texture request/response bus with N ports; rsp_texels and rsp_tag are broadcast.
// master issues requests and consumes responses, slave is the serving side.
interface vx_tex_arbiter_if #(
    parameter int N     = 1,
    parameter int TAG_W = 8
) ();
    import vx_tex_arbiter_pkg::*;

    logic [N-1:0]                                req_valid;
    logic [N-1:0][NUM_LANES-1:0]                 req_mask;
    logic [N-1:0][1:0][NUM_LANES-1:0][31:0]      req_coords;
    logic [N-1:0][NUM_LANES-1:0][LOD_BITS-1:0]   req_lod;
    logic [N-1:0][STAGE_BITS-1:0]                req_stage;
    logic [N-1:0][TAG_W-1:0]                     req_tag;
    logic [N-1:0]                                req_ready;

    logic [N-1:0]                                rsp_valid;
    logic [NUM_LANES-1:0][31:0]                  rsp_texels;
    logic [TAG_W-1:0]                            rsp_tag;
    logic [N-1:0]                                rsp_ready;

    modport master (
        output req_valid, req_mask, req_coords, req_lod, req_stage, req_tag, rsp_ready,
        input  req_ready, rsp_valid, rsp_texels, rsp_tag
    );

    modport slave (
        input  req_valid, req_mask, req_coords, req_lod, req_stage, req_tag, rsp_ready,
        output req_ready, rsp_valid, rsp_texels, rsp_tag
    );

endinterface

// File: rtl/vx_tex_arb_credit.sv
// Per-requester outstanding-request counter; a requester is eligible only
// while it holds fewer than MAX_PENDING requests in flight.
module vx_tex_arb_credit
    import vx_tex_arbiter_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic req_valid,
    input  logic req_fire,
    input  logic rsp_fire,
    output logic eligible
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // NOTE: every always_comb output gets its default first so no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (req_fire && !rsp_fire) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (rsp_fire && !req_fire) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // NOTE: state flops use non-blocking assignment; reset is sampled on the clock edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign eligible = req_valid && (cnt_q < CNT_W'(MAX_PENDING));

    a_no_overflow : assert property (@(posedge clk) disable iff (!reset)
        !(req_fire && !rsp_fire && (cnt_q == CNT_W'(MAX_PENDING))));

    a_no_underflow : assert property (@(posedge clk) disable iff (!reset)
        !(rsp_fire && !req_fire && (cnt_q == '0)));

endmodule

// File: rtl/vx_tex_arbiter.sv
// Round-robin share of one texture unit among NUM_REQS requesters, with per-requester
// credit limits and tag-indexed response routing. Define TEX_ARB_PERF_EN for perf counters.
module vx_tex_arbiter
    import vx_tex_arbiter_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    vx_tex_arbiter_if.slave  req_if,
    vx_tex_arbiter_if.master tex_if
`ifdef TEX_ARB_PERF_EN
    ,
    output logic [NUM_REQS-1:0][PERF_CTR_BITS-1:0] perf_stall_cycles,
    output logic [PERF_CTR_BITS-1:0]               perf_credit_stalls
`endif
);

    logic [NUM_REQS-1:0] eligible, req_fire_vec, rsp_fire_vec, rsp_valid_vec;
    logic [IDX_W-1:0]    last_grant_q, last_grant_d, grant_idx, cand, rsp_idx;
    logic                grant_valid, buf_in_ready, in_fire, rsp_idx_ok, tex_rsp_ready;
    tex_req_t            in_data, out_data_q, out_data_d, skid_data_q, skid_data_d;
    logic                out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;

    for (genvar i = 0; i < NUM_REQS; i++) begin : g_credit
        vx_tex_arb_credit u_credit (
            .clk      (clk),
            .reset    (reset),
            .req_valid(req_if.req_valid[i]),
            .req_fire (req_fire_vec[i]),
            .rsp_fire (rsp_fire_vec[i]),
            .eligible (eligible[i])
        );
    end

    // Scan from the requester after the last accepted grant.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NUM_REQS; k++) begin
            cand = IDX_W'((int'(last_grant_q) + 1 + k) % NUM_REQS);
            if (!grant_valid && eligible[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // The skid slot being free is the only space condition, so req_ready never
    // depends combinationally on tex_req_ready.
    assign buf_in_ready = reset && !skid_valid_q;

    always_comb begin
        req_fire_vec = '0;
        if (grant_valid && buf_in_ready) begin
            req_fire_vec[grant_idx] = 1'b1;
        end
    end

    assign req_if.req_ready = req_fire_vec;
    assign in_fire          = |req_fire_vec;
    assign last_grant_d     = in_fire ? grant_idx : last_grant_q;

    always_comb begin
        in_data.mask   = req_if.req_mask[grant_idx];
        in_data.coords = req_if.req_coords[grant_idx];
        in_data.lod    = req_if.req_lod[grant_idx];
        in_data.stage  = req_if.req_stage[grant_idx];
        in_data.tag    = {req_if.req_tag[grant_idx], grant_idx};
    end

    // Two-entry elastic buffer: registered output slot plus a skid slot.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (tex_if.req_ready[0] || !out_valid_q) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = in_fire;
                out_data_d  = in_data;
            end
        end else if (in_fire) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            last_grant_q <= IDX_W'(NUM_REQS - 1);
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    // NOTE: payload flops carry no reset; the valid bits alone qualify them.
    always_ff @(posedge clk) begin
        out_data_q  <= out_data_d;
        skid_data_q <= skid_data_d;
    end

    assign tex_if.req_valid[0]  = out_valid_q;
    assign tex_if.req_mask[0]   = out_data_q.mask;
    assign tex_if.req_coords[0] = out_data_q.coords;
    assign tex_if.req_lod[0]    = out_data_q.lod;
    assign tex_if.req_stage[0]  = out_data_q.stage;
    assign tex_if.req_tag[0]    = out_data_q.tag;

    assign rsp_idx    = tex_if.rsp_tag[IDX_W-1:0];
    assign rsp_idx_ok = int'(rsp_idx) < NUM_REQS;

    always_comb begin
        rsp_valid_vec = '0;
        tex_rsp_ready = 1'b0;
        if (reset && rsp_idx_ok) begin
            rsp_valid_vec[rsp_idx] = tex_if.rsp_valid[0];
            tex_rsp_ready          = req_if.rsp_ready[rsp_idx];
        end
    end

    assign req_if.rsp_valid  = rsp_valid_vec;
    assign req_if.rsp_texels = tex_if.rsp_texels;
    assign req_if.rsp_tag    = tex_if.rsp_tag[OUT_TAG_W-1:IDX_W];
    assign tex_if.rsp_ready  = tex_rsp_ready;
    assign rsp_fire_vec      = rsp_valid_vec & req_if.rsp_ready;

    a_rsp_idx_legal : assert property (@(posedge clk) disable iff (!reset)
        tex_if.rsp_valid[0] |-> rsp_idx_ok);

`ifdef TEX_ARB_PERF_EN
    logic [NUM_REQS-1:0][PERF_CTR_BITS-1:0] stall_cnt_q, stall_cnt_d;
    logic [PERF_CTR_BITS-1:0]               credit_cnt_q, credit_cnt_d;

    // A valid requester that is not eligible is blocked purely by its credit limit.
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        credit_cnt_d = credit_cnt_q;
        for (int i = 0; i < NUM_REQS; i++) begin
            if (req_if.req_valid[i] && !req_fire_vec[i]) begin
                stall_cnt_d[i] = stall_cnt_q[i] + PERF_CTR_BITS'(1);
            end
        end
        if (|(req_if.req_valid & ~eligible)) begin
            credit_cnt_d = credit_cnt_q + PERF_CTR_BITS'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt_q  <= '0;
            credit_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            credit_cnt_q <= credit_cnt_d;
        end
    end

    assign perf_stall_cycles  = stall_cnt_q;
    assign perf_credit_stalls = credit_cnt_q;
`endif

endmodule

// File: tb/tb_vx_tex_arbiter.sv
// Self-checking bench for vx_tex_arbiter: accepted requests are pushed to a
// scoreboard and popped when the texture unit side takes them.
module tb_vx_tex_arbiter;
    import vx_tex_arbiter_pkg::*;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    vx_tex_arbiter_if #(.N(NUM_REQS), .TAG_W(TAG_WIDTH)) req_bus ();
    vx_tex_arbiter_if #(.N(1),        .TAG_W(OUT_TAG_W)) tex_bus ();

`ifdef TEX_ARB_PERF_EN
    logic [NUM_REQS-1:0][PERF_CTR_BITS-1:0] perf_stall_cycles;
    logic [PERF_CTR_BITS-1:0]               perf_credit_stalls;
`endif

    vx_tex_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .req_if(req_bus),
        .tex_if(tex_bus)
`ifdef TEX_ARB_PERF_EN
        ,
        .perf_stall_cycles (perf_stall_cycles),
        .perf_credit_stalls(perf_credit_stalls)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    tex_req_t exp_q[$];
    int       grant_log[$];
    int       model_pend [NUM_REQS];

    logic [NUM_REQS-1:0]        smp_req_ready, smp_rsp_valid;
    logic                       smp_tex_valid, smp_tex_rsp_ready;
    logic [TAG_WIDTH-1:0]       smp_rsp_tag;
    logic [NUM_LANES-1:0][31:0] smp_rsp_texels;
    tex_req_t                   hold_pl;
    logic                       hold_act = 1'b0;

    task automatic check(input string tag, input logic [319:0] got, input logic [319:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int dut_pend(input int i);
        case (i)
            0:       return int'(dut.g_credit[0].u_credit.cnt_q);
            1:       return int'(dut.g_credit[1].u_credit.cnt_q);
            2:       return int'(dut.g_credit[2].u_credit.cnt_q);
            default: return int'(dut.g_credit[3].u_credit.cnt_q);
        endcase
    endfunction

    task automatic check_pend(input string tag);
        for (int i = 0; i < NUM_REQS; i++) check(tag, dut_pend(i), model_pend[i]);
    endtask

    task automatic new_payload(input int i);
        req_bus.req_mask[i] = NUM_LANES'($urandom);
        for (int c = 0; c < 2; c++)
            for (int l = 0; l < NUM_LANES; l++) req_bus.req_coords[i][c][l] = $urandom;
        for (int l = 0; l < NUM_LANES; l++) req_bus.req_lod[i][l] = LOD_BITS'($urandom);
        req_bus.req_stage[i] = STAGE_BITS'($urandom);
        req_bus.req_tag[i]   = TAG_WIDTH'($urandom);
    endtask

    function automatic tex_req_t dut_out();
        tex_req_t t;
        t.mask   = tex_bus.req_mask[0];
        t.coords = tex_bus.req_coords[0];
        t.lod    = tex_bus.req_lod[0];
        t.stage  = tex_bus.req_stage[0];
        t.tag    = tex_bus.req_tag[0];
        return t;
    endfunction

    // One clock: sample and score at the falling edge, then refresh fired payloads.
    task automatic step();
        logic [NUM_REQS-1:0] fired;
        tex_req_t e, got;
        @(negedge clk);
        smp_req_ready     = req_bus.req_ready;
        smp_rsp_valid     = req_bus.rsp_valid;
        smp_rsp_tag       = req_bus.rsp_tag;
        smp_rsp_texels    = req_bus.rsp_texels;
        smp_tex_valid     = tex_bus.req_valid[0];
        smp_tex_rsp_ready = tex_bus.rsp_ready[0];
        fired = req_bus.req_valid & req_bus.req_ready;
        got   = dut_out();
        for (int i = 0; i < NUM_REQS; i++) begin
            if (req_bus.rsp_valid[i] && req_bus.rsp_ready[i]) model_pend[i]--;
            if (fired[i]) begin
                e.mask   = req_bus.req_mask[i];
                e.coords = req_bus.req_coords[i];
                e.lod    = req_bus.req_lod[i];
                e.stage  = req_bus.req_stage[i];
                e.tag    = {req_bus.req_tag[i], IDX_W'(i)};
                exp_q.push_back(e);
                grant_log.push_back(i);
                model_pend[i]++;
            end
        end
        if (tex_bus.req_valid[0] && !tex_bus.req_ready[0]) begin
            if (hold_act) check("hold_stable", got, hold_pl);
            hold_pl  = got;
            hold_act = 1'b1;
        end else begin
            hold_act = 1'b0;
        end
        if (tex_bus.req_valid[0] && tex_bus.req_ready[0]) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL tex_req_unexpected: got %0h expected no request", got);
            end else begin
                check("tex_req", got, exp_q.pop_front());
            end
        end
        if (!reset) begin
            exp_q.delete();
            for (int i = 0; i < NUM_REQS; i++) model_pend[i] = 0;
            hold_act = 1'b0;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_REQS; i++) if (fired[i]) new_payload(i);
    endtask

    task automatic send_rsp(input int idx, input int count);
        tex_bus.rsp_valid  = 1'b1;
        tex_bus.rsp_tag    = {TAG_WIDTH'($urandom), IDX_W'(idx)};
        req_bus.rsp_ready  = '1;
        for (int k = 0; k < count; k++) step();
        tex_bus.rsp_valid  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int accepts;
        logic [3:0] rdy_seq [5];
        reset              = 1'b0;
        req_bus.req_valid  = '0;
        req_bus.rsp_ready  = '0;
        tex_bus.req_ready  = '0;
        tex_bus.rsp_valid  = '0;
        tex_bus.rsp_tag    = '0;
        tex_bus.rsp_texels = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            new_payload(i);
            model_pend[i] = 0;
        end
        @(posedge clk);
        #1;

        // Reset state
        step();
        step();
        check("rst_tex_valid", smp_tex_valid, 1'b0);
        check("rst_req_ready", smp_req_ready, 4'b0000);
        check("rst_rsp_valid", smp_rsp_valid, 4'b0000);
        for (int i = 0; i < NUM_REQS; i++) check("rst_pend", dut_pend(i), 0);

        // Round-robin fairness until every requester runs out of credit
        reset             = 1'b1;
        req_bus.req_valid = '1;
        tex_bus.req_ready = 1'b1;
        grant_log.delete();
        step();
        check("lat_first_ready", smp_req_ready, 4'b0001);
        check("lat_first_tex_valid", smp_tex_valid, 1'b0);
        step();
        check("lat_second_tex_valid", smp_tex_valid, 1'b1);
        for (int k = 0; k < 38; k++) step();
        check("rr_grant_count", grant_log.size(), 4 * MAX_PENDING);
        for (int k = 0; k < grant_log.size(); k++) check("rr_order", grant_log[k], k % NUM_REQS);
        check("rr_credit_block", smp_req_ready, 4'b0000);
        for (int i = 0; i < NUM_REQS; i++) check("rr_pend_full", dut_pend(i), MAX_PENDING);

        // Credit return to requester 2
        tex_bus.rsp_texels = {$urandom, $urandom, $urandom, $urandom};
        send_rsp(2, 1);
        check("cr_rsp_valid", smp_rsp_valid, 4'b0100);
        check("cr_ready_same_cycle", smp_req_ready, 4'b0000);
        step();
        check("cr_regrant", smp_req_ready, 4'b0100);
        step();
        check("cr_single_grant", smp_req_ready, 4'b0000);
        step();
        check_pend("cr_pend");

        // Simultaneous request and response fire for requester 1
        req_bus.req_valid = '0;
        send_rsp(1, 5);
        check("sim_pend_before", dut_pend(1), 3);
        req_bus.req_valid = 4'b0010;
        send_rsp(1, 1);
        check("sim_req_ready", smp_req_ready, 4'b0010);
        check("sim_rsp_valid", smp_rsp_valid, 4'b0010);
        req_bus.req_valid = '0;
        check("sim_pend_after", dut_pend(1), 3);
        step();
        check_pend("sim_pend");

        // Backpressure: two accepts, then requester 0 is held off
        send_rsp(0, 6);
        tex_bus.req_ready = 1'b0;
        req_bus.req_valid = 4'b0001;
        accepts = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            rdy_seq[k] = smp_req_ready;
            if (smp_req_ready[0]) accepts++;
        end
        check("bp_accepts", accepts, 2);
        check("bp_ready_seq", {rdy_seq[0], rdy_seq[1], rdy_seq[2], rdy_seq[3], rdy_seq[4]},
              {4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000});
        check("bp_queued", exp_q.size(), 2);
        req_bus.req_valid = '0;
        tex_bus.req_ready = 1'b1;
        for (int k = 0; k < 3; k++) step();
        check("bp_drained", exp_q.size(), 0);
        check("bp_tex_idle", smp_tex_valid, 1'b0);
        check("bp_pend0", dut_pend(0), 4);

        // Response routing
        tex_bus.rsp_texels = {$urandom, $urandom, $urandom, $urandom};
        tex_bus.rsp_valid  = 1'b1;
        tex_bus.rsp_tag    = {8'hA5, 2'd3};
        req_bus.rsp_ready  = 4'b0111;
        step();
        check("rt_rsp_valid", smp_rsp_valid, 4'b1000);
        check("rt_rsp_tag", smp_rsp_tag, 8'hA5);
        check("rt_tex_rsp_ready", smp_tex_rsp_ready, 1'b0);
        check("rt_texels", smp_rsp_texels, tex_bus.rsp_texels);
        tex_bus.rsp_tag   = {8'h3C, 2'd0};
        req_bus.rsp_ready = 4'b0001;
        step();
        check("rt0_rsp_valid", smp_rsp_valid, 4'b0001);
        check("rt0_rsp_tag", smp_rsp_tag, 8'h3C);
        check("rt0_tex_rsp_ready", smp_tex_rsp_ready, 1'b1);
        tex_bus.rsp_valid = 1'b0;
        check_pend("rt_pend");

        // Mid-stream reset with two requests buffered
        tex_bus.req_ready = 1'b0;
        req_bus.req_valid = 4'b0001;
        for (int k = 0; k < 3; k++) step();
        check("mr_buffered", exp_q.size(), 2);
        reset             = 1'b0;
        req_bus.req_valid = '0;
        step();
        check("mr_ready_in_reset", smp_req_ready, 4'b0000);
        reset             = 1'b1;
        req_bus.req_valid = '1;
        tex_bus.req_ready = 1'b1;
        for (int i = 0; i < NUM_REQS; i++) check("mr_pend_clear", dut_pend(i), 0);
        step();
        check("mr_tex_valid", smp_tex_valid, 1'b0);
        check("mr_first_grant", smp_req_ready, 4'b0001);
        step();
        check("mr_tex_valid_next", smp_tex_valid, 1'b1);
        check("mr_second_grant", smp_req_ready, 4'b0010);
        req_bus.req_valid = '0;
        for (int k = 0; k < 3; k++) step();
        check("end_sb_empty", exp_q.size(), 0);
        check_pend("end_pend");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
